csr_access_unit: RTL

- Sequences one CSR instruction (CSRRW/RS/RC and immediate forms) against the CSR register file.
- Accepts a request from the execute stage and drives the CSR file's select/write-enable/write-data. Reads the old value, computes the read-modify-write value, writes it back, and returns the old value as the rd result.
- Flags illegal accesses instead of writing.
- Sits directly upstream of the CSR register file; one request in flight at a time.

---
 rtl/csr_access_unit_if.sv | 32 +++
 rtl/csr_access_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/csr_access_unit_if.sv
// Bundles the execute-stage request, response and CSR-file access signals
// of csr_access_unit; slave is the unit side, master is the environment.
interface csr_access_unit_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  req_funct3_i;
   logic [11:0] req_addr_i;
   logic [31:0] req_rs1_val_i;
   logic [4:0]  req_rs1_idx_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_rdata_o;
   logic        resp_illegal_o;
   logic [11:0] csr_sel_o;
   logic        csr_we_o;
   logic [31:0] csr_din_o;
   logic [31:0] csr_dout_i;

   modport slave (
      input  req_valid_i, req_funct3_i, req_addr_i, req_rs1_val_i, req_rs1_idx_i,
      input  resp_ready_i, csr_dout_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_illegal_o,
      output csr_sel_o, csr_we_o, csr_din_o
   );

   modport master (
      output req_valid_i, req_funct3_i, req_addr_i, req_rs1_val_i, req_rs1_idx_i,
      output resp_ready_i, csr_dout_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_illegal_o,
      input  csr_sel_o, csr_we_o, csr_din_o
   );
endinterface

// File: rtl/csr_access_unit.sv
// Sequences one CSRRW/RS/RC (register or immediate form) as read, optional
// write-back, then response carrying the old CSR value.
module csr_access_unit #(
   parameter bit CHECK_ADDR = 1'b1
) (
   input logic               clk_i,
   input logic               reset_i,
   csr_access_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

   state_e      state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] rs1_val_q, rs1_val_d;
   logic [4:0]  rs1_idx_q, rs1_idx_d;
   logic [31:0] old_q, old_d;
   logic        illegal_q, illegal_d;

   logic [31:0] src;
   logic [31:0] new_val;
   logic        do_write;
   logic        illegal_now;

   function automatic logic addr_listed(input logic [11:0] a);
      case (a)
         12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

   // Operand and legality decode work on latched fields only.
   always_comb begin
      src         = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_val_q;
      do_write    = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
      illegal_now = (funct3_q[1:0] == 2'b00)
                 || (do_write && (addr_q[11:10] == 2'b11))
                 || (CHECK_ADDR && !addr_listed(addr_q));
      case (funct3_q[1:0])
         2'b01:   new_val = src;
         2'b10:   new_val = old_q | src;
         2'b11:   new_val = old_q & ~src;
         default: new_val = old_q;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d            = state_q;
      funct3_d           = funct3_q;
      addr_d             = addr_q;
      rs1_val_d          = rs1_val_q;
      rs1_idx_d          = rs1_idx_q;
      old_d              = old_q;
      illegal_d          = illegal_q;
      bus.req_ready_o    = 1'b0;
      bus.resp_valid_o   = 1'b0;
      bus.resp_rdata_o   = 32'd0;
      bus.resp_illegal_o = 1'b0;
      bus.csr_sel_o      = 12'd0;
      bus.csr_we_o       = 1'b0;
      bus.csr_din_o      = 32'd0;

      case (state_q)
         IDLE: begin
            bus.req_ready_o = 1'b1;
            if (bus.req_valid_i) begin
               funct3_d  = bus.req_funct3_i;
               addr_d    = bus.req_addr_i;
               rs1_val_d = bus.req_rs1_val_i;
               rs1_idx_d = bus.req_rs1_idx_i;
               state_d   = READ;
            end
         end
         READ: begin
            bus.csr_sel_o = addr_q;
            old_d         = bus.csr_dout_i;
            illegal_d     = illegal_now;
            state_d       = (do_write && !illegal_now) ? WRITE : RESP;
         end
         WRITE: begin
            bus.csr_sel_o = addr_q;
            bus.csr_we_o  = 1'b1;
            bus.csr_din_o = new_val;
            state_d       = RESP;
         end
         RESP: begin
            bus.resp_valid_o   = 1'b1;
            bus.resp_rdata_o   = illegal_q ? 32'd0 : old_q;
            bus.resp_illegal_o = illegal_q;
            if (bus.resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         funct3_q  <= 3'd0;
         addr_q    <= 12'd0;
         rs1_val_q <= 32'd0;
         rs1_idx_q <= 5'd0;
         old_q     <= 32'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         rs1_val_q <= rs1_val_d;
         rs1_idx_q <= rs1_idx_d;
         old_q     <= old_d;
         illegal_q <= illegal_d;
      end
   end

endmodule
